// File: rtl/sq_mem_controller.sv
// sq_mem_controller
//  Responder for the calculator command interface. Executes push / pop / add
//  commands on a DEPTH x DW single-port memory organised either as a stack
//  (LIFO, stackQueue = 0) or a circular queue (FIFO, stackQueue = 1).
//  Drives the display value plus occupancy count and empty/full flags.
//  Optional feature macro: SQ_SAT_ADD_EN -- add saturates to all-ones on
//  carry-out and flags err with done; otherwise the sum wraps silently.
module sq_mem_controller #(
    parameter int DW    = 16,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stackQueue,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic          cmd_ready,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] disp,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_TWO  = AW'(2);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        LAT_B,
        WR,
        DONE,
        ERR
    } state_t;

    state_t state_reg, state_next;

    // Architectural state
    logic          mode_reg;
    logic [AW:0]   count_reg;
    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [DW-1:0] disp_reg;

    // Per-command working registers, loaded when a command is accepted
    logic [1:0]    op_reg;
    logic [DW-1:0] data_reg;
    logic [AW-1:0] addr_a_reg;
    logic [AW-1:0] addr_b_reg;
    logic [AW-1:0] addr_w_reg;

    // Single-port memory with registered read
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_reg;
    logic [AW-1:0] rd_addr;
    logic          wr_en;

    logic          is_empty;
    logic          is_full;
    logic          reject;
    logic          accept;
    logic          start;
    logic [AW-1:0] cnt_lo;
    logic [DW-1:0] sum;

`ifdef SQ_SAT_ADD_EN
    logic          carry;
    logic          sat_reg;
`endif

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == CNT_FULL);
    assign cnt_lo   = count_reg[AW-1:0];

    assign accept = (state_reg == IDLE) && cmd_valid;
    assign start  = accept && !reject;

    // Legality of the offered command against the current occupancy
    always_comb begin
        reject = 1'b0;
        case (cmd_op)
            OP_PUSH: reject = is_full;
            OP_POP:  reject = is_empty;
            OP_ADD:  reject = (count_reg < CNT_TWO);
            default: reject = 1'b1;
        endcase
    end

    // Adder: the first operand sits in data_reg, the second arrives on the read port
`ifdef SQ_SAT_ADD_EN
    always_comb begin
        {carry, sum} = {1'b0, data_reg} + {1'b0, rd_data_reg};
        if (carry) begin
            sum = '1;
        end
    end
`else
    assign sum = data_reg + rd_data_reg;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state sequencing; push skips the reads, add needs a second read and a latch cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    if (reject) begin
                        state_next = ERR;
                    end else if (cmd_op == OP_PUSH) begin
                        state_next = WR;
                    end else begin
                        state_next = RD_A;
                    end
                end
            end
            RD_A:    state_next = RD_B;
            RD_B:    state_next = (op_reg == OP_ADD) ? LAT_B : DONE;
            LAT_B:   state_next = WR;
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory port: B address only while RD_B, otherwise A address; write only in WR
    assign rd_addr = (state_reg == RD_B) ? addr_b_reg : addr_a_reg;
    assign wr_en   = (state_reg == WR);

    // Memory array; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_w_reg] <= data_reg;
        end
        rd_data_reg <= mem[rd_addr];
    end

    // Datapath: capture addresses at accept, move data through the read pipeline,
    // and commit count/pointers/disp on the edge that enters DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg   <= 1'b0;
            count_reg  <= '0;
            head_reg   <= '0;
            tail_reg   <= '0;
            disp_reg   <= '0;
            op_reg     <= OP_PUSH;
            data_reg   <= '0;
            addr_a_reg <= '0;
            addr_b_reg <= '0;
            addr_w_reg <= '0;
`ifdef SQ_SAT_ADD_EN
            sat_reg    <= 1'b0;
`endif
        end else begin
            // Organisation may only change while the memory holds nothing
            if ((state_reg == IDLE) && is_empty) begin
                mode_reg <= stackQueue;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg   <= cmd_op;
                        data_reg <= cmd_data;
`ifdef SQ_SAT_ADD_EN
                        sat_reg  <= 1'b0;
`endif
                        if (mode_reg) begin
                            // Queue: operands come from the head, results go to the tail
                            addr_a_reg <= head_reg;
                            addr_b_reg <= head_reg + PTR_ONE;
                            addr_w_reg <= tail_reg;
                        end else begin
                            // Stack: top is count-1; add result replaces the second entry
                            addr_a_reg <= cnt_lo - PTR_ONE;
                            addr_b_reg <= cnt_lo - PTR_TWO;
                            addr_w_reg <= (cmd_op == OP_PUSH) ? cnt_lo : (cnt_lo - PTR_TWO);
                        end
                    end
                end
                RD_B: begin
                    // Read of A has landed; for pop this is the final result
                    data_reg <= rd_data_reg;
                    if (op_reg == OP_POP) begin
                        disp_reg  <= rd_data_reg;
                        count_reg <= count_reg - CNT_ONE;
                        if (mode_reg) begin
                            head_reg <= head_reg + PTR_ONE;
                        end
                    end
                end
                LAT_B: begin
                    data_reg <= sum;
`ifdef SQ_SAT_ADD_EN
                    sat_reg  <= carry;
`endif
                end
                WR: begin
                    disp_reg <= data_reg;
                    if (op_reg == OP_PUSH) begin
                        count_reg <= count_reg + CNT_ONE;
                        if (mode_reg) begin
                            tail_reg <= tail_reg + PTR_ONE;
                        end
                    end else begin
                        // add: two entries consumed, one produced
                        count_reg <= count_reg - CNT_ONE;
                        if (mode_reg) begin
                            head_reg <= head_reg + PTR_TWO;
                            tail_reg <= tail_reg + PTR_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign done      = (state_reg == DONE) || (state_reg == ERR);
`ifdef SQ_SAT_ADD_EN
    assign err       = (state_reg == ERR) || ((state_reg == DONE) && sat_reg);
`else
    assign err       = (state_reg == ERR);
`endif
    assign disp      = disp_reg;
    assign count     = count_reg;
    assign empty     = is_empty;
    assign full      = is_full;

endmodule

// File: tb/tb_sq_mem_controller.sv
// tb_sq_mem_controller
//  Self-checking bench for sq_mem_controller: directed stack/queue scenarios,
//  a table of queue-mode vectors with rejections, a mid-operation reset, the
//  add overflow case (SQ_SAT_ADD_EN aware), and randomized commands checked
//  against a queue-based reference model.
module tb_sq_mem_controller;

    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    localparam logic [1:0] PUSH = 2'b00;
    localparam logic [1:0] POP  = 2'b01;
    localparam logic [1:0] ADD  = 2'b10;
    localparam logic [1:0] RSV  = 2'b11;

`ifdef SQ_SAT_ADD_EN
    localparam int OVF_DISP = 16'hFFFF;
    localparam int OVF_ERR  = 1;
`else
    localparam int OVF_DISP = 16'h0001;
    localparam int OVF_ERR  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stackQueue = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = 2'b00;
    logic [DW-1:0] cmd_data = '0;
    logic          cmd_ready;
    logic          done;
    logic          err;
    logic [DW-1:0] disp;
    logic [AW:0]   count;
    logic          empty;
    logic          full;

    int n_err = 0;
    int n_chk = 0;
    int txn   = 0;

    // Reference model: contents in logical order, oldest/bottom first
    logic [DW-1:0] mq[$];
    logic          m_mode;
    logic [DW-1:0] m_disp;

    // Observations from the most recent command
    logic          a_err;
    logic          a_empty;
    logic          a_full;
    logic [DW-1:0] a_disp;
    int            a_cnt;
    int            a_lat;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] data;
        logic          e_err;
        logic [DW-1:0] e_disp;
        int            e_cnt;
        int            e_lat;
    } vec_t;

    vec_t tbl[14];

    sq_mem_controller #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .stackQueue (stackQueue),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .done       (done),
        .err        (err),
        .disp       (disp),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset(input logic sq);
        @(negedge clk);
        rst        = 1'b1;
        stackQueue = sq;
        cmd_valid  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mq.delete();
        m_disp = '0;
        m_mode = sq;
    endtask

    // Only called with an empty model, so the DUT is free to reload its mode
    task automatic set_mode(input logic m);
        @(negedge clk);
        stackQueue = m;
        @(negedge clk);
        m_mode = m;
    endtask

    // Issue one command, measure cycles from accept to done, capture outputs
    task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] data);
        int lat;
        @(negedge clk);
        check("ready_idle", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = ~data;
        lat = 1;
        while (!done && lat < 12) begin
            check("ready_busy", int'(cmd_ready), 0);
            @(negedge clk);
            lat++;
        end
        a_lat   = done ? lat : -1;
        a_err   = err;
        a_disp  = disp;
        a_cnt   = int'(count);
        a_empty = empty;
        a_full  = full;
        @(negedge clk);
        check("done_pulse", int'(done), 0);
        txn++;
        $display("txn %0d op=%0d data=0x%0h -> lat=%0d err=%0b disp=0x%0h count=%0d",
                 txn, op, data, a_lat, a_err, a_disp, a_cnt);
    endtask

    // Apply a command to the model and the DUT and compare everything observable
    task automatic model_cmd(input logic [1:0] op, input logic [DW-1:0] data);
        logic          rej;
        logic          e_err;
        int            e_lat;
        logic [DW:0]   s;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        rej   = 1'b0;
        e_err = 1'b0;
        e_lat = 1;
        case (op)
            PUSH: begin
                if (mq.size() == DEPTH) rej = 1'b1;
                else begin
                    mq.push_back(data);
                    m_disp = data;
                    e_lat  = 2;
                end
            end
            POP: begin
                if (mq.size() == 0) rej = 1'b1;
                else begin
                    m_disp = m_mode ? mq.pop_front() : mq.pop_back();
                    e_lat  = 3;
                end
            end
            ADD: begin
                if (mq.size() < 2) rej = 1'b1;
                else begin
                    if (m_mode) begin
                        x = mq.pop_front();
                        y = mq.pop_front();
                    end else begin
                        x = mq.pop_back();
                        y = mq.pop_back();
                    end
                    s = {1'b0, x} + {1'b0, y};
`ifdef SQ_SAT_ADD_EN
                    if (s[DW]) begin
                        e_err = 1'b1;
                        s     = '1;
                    end
`endif
                    m_disp = s[DW-1:0];
                    mq.push_back(m_disp);
                    e_lat = 5;
                end
            end
            default: rej = 1'b1;
        endcase
        if (rej) e_err = 1'b1;
        run_cmd(op, data);
        check("m_lat",   a_lat,          e_lat);
        check("m_err",   int'(a_err),    int'(e_err));
        check("m_disp",  int'(a_disp),   int'(m_disp));
        check("m_count", a_cnt,          mq.size());
        check("m_empty", int'(a_empty),  int'(mq.size() == 0));
        check("m_full",  int'(a_full),   int'(mq.size() == DEPTH));
    endtask

    initial begin
        int n_done;

        // Queue-mode vectors with rejections sprinkled in
        tbl[0]  = '{PUSH, 16'd1, 1'b0, 16'd1, 1, 2};
        tbl[1]  = '{PUSH, 16'd2, 1'b0, 16'd2, 2, 2};
        tbl[2]  = '{PUSH, 16'd3, 1'b0, 16'd3, 3, 2};
        tbl[3]  = '{PUSH, 16'd4, 1'b0, 16'd4, 4, 2};
        tbl[4]  = '{ADD,  16'd0, 1'b0, 16'd3, 3, 5};
        tbl[5]  = '{POP,  16'd0, 1'b0, 16'd3, 2, 3};
        tbl[6]  = '{POP,  16'd0, 1'b0, 16'd4, 1, 3};
        tbl[7]  = '{POP,  16'd0, 1'b0, 16'd3, 0, 3};
        tbl[8]  = '{POP,  16'd0, 1'b1, 16'd3, 0, 1};
        tbl[9]  = '{ADD,  16'd0, 1'b1, 16'd3, 0, 1};
        tbl[10] = '{PUSH, 16'd7, 1'b0, 16'd7, 1, 2};
        tbl[11] = '{ADD,  16'd0, 1'b1, 16'd7, 1, 1};
        tbl[12] = '{RSV,  16'd9, 1'b1, 16'd7, 1, 1};
        tbl[13] = '{POP,  16'd0, 1'b0, 16'd7, 0, 3};

        // Reset state
        do_reset(1'b0);
        check("rst_count", int'(count),     0);
        check("rst_empty", int'(empty),     1);
        check("rst_full",  int'(full),      0);
        check("rst_done",  int'(done),      0);
        check("rst_err",   int'(err),       0);
        check("rst_disp",  int'(disp),      0);
        check("rst_ready", int'(cmd_ready), 1);

        // Stack fill to full, then one push too many
        for (int i = 0; i < DEPTH; i++) model_cmd(PUSH, DW'(i + 1));
        check("fill_full", int'(a_full), 1);
        check("fill_disp", int'(a_disp), 32);
        model_cmd(PUSH, 16'd99);
        check("ovfpush_err",   int'(a_err),  1);
        check("ovfpush_count", a_cnt,        32);
        check("ovfpush_disp",  int'(a_disp), 32);

        // Stack add down to a single entry
        model_cmd(ADD, '0);
        check("add1_disp", int'(a_disp), 63);
        for (int i = 1; i < DEPTH - 1; i++) model_cmd(ADD, '0);
        check("addall_disp",  int'(a_disp), 528);
        check("addall_count", a_cnt,        1);

        // Queue-mode vector table
        do_reset(1'b1);
        for (int i = 0; i < 14; i++) begin
            run_cmd(tbl[i].op, tbl[i].data);
            check($sformatf("tbl%0d_lat", i),   a_lat,              tbl[i].e_lat);
            check($sformatf("tbl%0d_err", i),   int'(a_err),        int'(tbl[i].e_err));
            check($sformatf("tbl%0d_disp", i),  int'(a_disp),       int'(tbl[i].e_disp));
            check($sformatf("tbl%0d_count", i), a_cnt,              tbl[i].e_cnt);
            check($sformatf("tbl%0d_empty", i), int'(a_empty),      int'(tbl[i].e_cnt == 0));
        end
        m_disp = 16'd7;

        // Queue wrap-around
        for (int i = 0; i < DEPTH; i++) model_cmd(PUSH, DW'(i + 1));
        for (int i = 0; i < 5; i++) model_cmd(POP, '0);
        check("wrap_pop5_disp", int'(a_disp), 5);
        for (int i = 0; i < 5; i++) model_cmd(PUSH, DW'(101 + i));
        check("wrap_full", int'(a_full), 1);
        model_cmd(ADD, '0);
        check("wrap_addfull_disp", int'(a_disp), 13);
        for (int i = 0; i < DEPTH - 1; i++) model_cmd(POP, '0);
        check("wrap_last_disp", int'(a_disp), 13);
        check("wrap_empty",     int'(a_empty), 1);

        // Reset while an add sits in RD_B: abort without a done pulse
        model_cmd(PUSH, 16'd5);
        model_cmd(PUSH, 16'd6);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(cmd_ready), 0);
        rst    = 1'b1;
        n_done = 0;
        @(negedge clk);
        rst = 1'b0;
        if (done) n_done++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_nodone", n_done,          0);
        check("midrst_count",  int'(count),     0);
        check("midrst_empty",  int'(empty),     1);
        check("midrst_disp",   int'(disp),      0);
        check("midrst_ready",  int'(cmd_ready), 1);
        mq.delete();
        m_disp = '0;
        m_mode = stackQueue;

        // Add overflow in stack mode
        set_mode(1'b0);
        model_cmd(PUSH, 16'hFFFF);
        model_cmd(PUSH, 16'h0002);
        model_cmd(ADD, '0);
        check("ovf_disp", int'(a_disp), OVF_DISP);
        check("ovf_err",  int'(a_err),  OVF_ERR);

        // Randomized commands against the model: fill-biased, then drain-biased
        for (int i = 0; i < 300; i++) begin
            int            r;
            logic [1:0]    op;
            logic [DW-1:0] d;
            if (mq.size() == 0 && $urandom_range(0, 2) == 0) set_mode(1'($urandom_range(0, 1)));
            r = $urandom_range(0, 9);
            if (i < 150) op = (r < 6) ? PUSH : (r < 8) ? POP : (r < 9) ? ADD : RSV;
            else         op = (r < 3) ? PUSH : (r < 6) ? POP : (r < 9) ? ADD : RSV;
            d = DW'($urandom);
            model_cmd(op, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
